// File: rtl/memory_arbiter.sv
// Round-robin N-port arbiter sharing one valid/ready memory port; request fields latched at grant.
// Latency: grant 1 cycle after m_valid seen in IDLE; m_ready/m_rdata pass through combinationally with mem_ready.
// Backpressure: one outstanding transaction; requesters hold m_valid until m_ready. Optional timeout: MEM_ARB_TIMEOUT_EN.
module memory_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              m_valid,
  input  logic [NUM_PORTS-1:0]              m_instr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_wstrb,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_PORTS-1:0]              m_ready,
  output logic [NUM_PORTS-1:0]              m_error,
  output logic                              mem_valid,
  output logic                              mem_instr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [DATA_WIDTH/8-1:0]           mem_wstrb,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("memory_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic             instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;

  logic             pick_vld;
  int               pick_sel;
  int               cand;
  logic             done_w;
  logic             timeout_w;
  logic             finish_w;
  logic [NUM_PORTS-1:0] grant_oh;

  // Round-robin search: first requester after the last granted port, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_sel = 0;
    cand     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_q) + k) % NUM_PORTS;
      if (!pick_vld && m_valid[cand]) begin
        pick_vld = 1'b1;
        pick_sel = cand;
      end
    end
  end

  assign done_w   = (state_q == BUSY) && mem_ready;
  assign finish_w = done_w || timeout_w;
  assign grant_oh = NUM_PORTS'(1) << grant_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count BUSY cycles; held at zero in IDLE so each transaction starts fresh.
  always_comb begin
    tmo_cnt_d = (state_q == BUSY) ? tmo_cnt_q + 1'b1 : '0;
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end

  // A real mem_ready on the final cycle takes precedence over the timeout.
  assign timeout_w = (state_q == BUSY) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !mem_ready;
`else
  assign timeout_w = 1'b0;
`endif

  // Next-state: arbitrate and latch fields in IDLE, wait for completion in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = IW'(pick_sel);
          last_d  = IW'(pick_sel);
          instr_d = m_instr[pick_sel];
          addr_d  = m_addr[pick_sel*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = m_wdata[pick_sel*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d = m_wstrb[pick_sel*SW +: SW];
        end
      end
      BUSY: begin
        if (finish_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_valid = (state_q == BUSY);
  assign mem_instr = instr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign m_ready = finish_w  ? grant_oh  : '0;
  assign m_error = timeout_w ? grant_oh  : '0;
  assign m_rdata = done_w    ? mem_rdata : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with four ports and an 8-cycle timeout parameter.
// Covers reset, round robin, field latching, single read, tie-break, timeout or indefinite wait, async reset.
// Memory side is driven directly by the stimulus; expected values are hand-computed constants.
module tb_memory_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   m_valid, m_instr;
  logic [NP*AW-1:0] m_addr;
  logic [NP*DW-1:0] m_wdata;
  logic [NP*DW/8-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [NP-1:0]   m_ready, m_error;
  logic            mem_valid, mem_instr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  memory_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic ins);
    m_addr[p*AW +: AW]       = a;
    m_wdata[p*DW +: DW]      = d;
    m_wstrb[p*DW/8 +: DW/8]  = s;
    m_instr[p]               = ins;
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0;
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_error", m_error, 0);
    #2 rst = 1'b1;
    tick();

    // Round robin: all four ports request continuously; port 0 first after reset.
    for (int p = 0; p < NP; p++) set_port(p, 32'h1000 + 32'(p * 4), 32'h0, 4'h0, 1'b0);
    m_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rr_mem_valid", mem_valid, 1);
      chk("rr_grant_addr", mem_addr, 64'h1000 + 64'(exp_seq[t] * 4));
      chk("rr_no_early_ready", m_ready, 0);
      mem_ready = 1'b1;
      mem_rdata = 32'hA0 + 32'(t);
      #1;
      chk("rr_m_ready", m_ready, 64'(1) << exp_seq[t]);
      chk("rr_m_rdata", m_rdata, 64'hA0 + 64'(t));
      chk("rr_m_error", m_error, 0);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("rr_idle_gap", mem_valid, 0);
    end

    // Write latching: port 0 changes its fields after grant.
    m_valid = 4'b0001;
    set_port(0, 32'h20, 32'h12345678, 4'h3, 1'b0);
    tick();
    set_port(0, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b1);
    tick();
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_mem_wstrb", mem_wstrb, 4'h3);
    chk("wr_mem_instr", mem_instr, 0);
    mem_ready = 1'b1;
    #1;
    chk("wr_m_ready", m_ready, 4'b0001);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0000;

    // Single read from port 1, memory answers three cycles into BUSY.
    set_port(1, 32'h100, 32'h0, 4'h0, 1'b1);
    m_valid = 4'b0010;
    tick();
    chk("rd_mem_valid", mem_valid, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_wstrb", mem_wstrb, 0);
    chk("rd_mem_instr", mem_instr, 1);
    tick();
    tick();
    chk("rd_wait_ready", m_ready, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m_ready", m_ready, 4'b0010);
    chk("rd_m_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0000;
    #1;
    chk("rd_rdata_gated", m_rdata, 0);
    mem_ready = 1'b1;
    #1;
    chk("idle_stray_ready", m_ready, 0);
    tick();
    chk("idle_stray_no_busy", mem_valid, 0);
    mem_ready = 1'b0;

    // Port 1 was served last: with 0 and 1 both requesting, port 0 wins.
    set_port(0, 32'h200, 32'h0, 4'h0, 1'b0);
    set_port(1, 32'h300, 32'h0, 4'h0, 1'b0);
    m_valid = 4'b0011;
    tick();
    chk("tie_addr0", mem_addr, 32'h200);
    mem_ready = 1'b1;
    #1;
    chk("tie_ready0", m_ready, 4'b0001);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0010;
    tick();
    chk("tie_addr1", mem_addr, 32'h300);
    mem_ready = 1'b1;
    #1;
    chk("tie_ready1", m_ready, 4'b0010);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0000;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: timeout completes in the 8th BUSY cycle.
    set_port(3, 32'h3000, 32'h0, 4'h0, 1'b0);
    m_valid = 4'b1000;
    mem_rdata = 32'h55;
    tick();
    for (int c = 1; c < 8; c++) begin
      chk("tmo_wait_ready", m_ready, 0);
      tick();
    end
    chk("tmo_m_ready", m_ready, 4'b1000);
    chk("tmo_m_error", m_error, 4'b1000);
    chk("tmo_m_rdata", m_rdata, 0);
    m_valid = 4'b0000;
    tick();
    chk("tmo_back_idle", mem_valid, 0);
    mem_ready = 1'b1;
    #1;
    chk("tmo_stray_ready", m_ready, 0);
    chk("tmo_stray_error", m_error, 0);
    tick();
    mem_ready = 1'b0;
    set_port(0, 32'h44, 32'h0, 4'h0, 1'b0);
    m_valid = 4'b0001;
    tick();
    chk("tmo_next_addr", mem_addr, 32'h44);
    mem_ready = 1'b1;
    #1;
    chk("tmo_next_ready", m_ready, 4'b0001);
    chk("tmo_next_error", m_error, 0);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0000;
`endif

    // Reset while BUSY on port 1; afterwards ports 1 and 2 request, port 1 must win.
    set_port(1, 32'h700, 32'h0, 4'h0, 1'b0);
    set_port(2, 32'h800, 32'h0, 4'h0, 1'b0);
    m_valid = 4'b0010;
    tick();
    repeat (5) tick();
`ifndef MEM_ARB_TIMEOUT_EN
    repeat (20) tick();
    chk("no_tmo_still_busy", mem_valid, 1);
    chk("no_tmo_no_ready", m_ready, 0);
`endif
    chk("busy_before_rst", mem_valid, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h77;
    rst = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_m_ready", m_ready, 0);
    chk("arst_m_error", m_error, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_m_rdata", m_rdata, 0);
    mem_ready = 1'b0;
    m_valid = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_no_ready", m_ready, 0);
    tick();
    chk("post_rst_grant", mem_addr, 32'h700);
    mem_ready = 1'b1;
    #1;
    chk("post_rst_ready", m_ready, 4'b0010);
    tick();
    mem_ready = 1'b0;
    m_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
